// File: rtl/tb_obi_resp_pkg.sv
// rtl/tb_obi_resp_pkg.sv - shared types and constants for the OBI data-port responder
package tb_obi_resp_pkg;

  typedef enum logic [1:0] {
    GS_IDLE  = 2'd0,
    GS_STALL = 2'd1,
    GS_GRANT = 2'd2
  } gnt_state_e;

  localparam logic [31:0] ERR_RDATA = 32'hBADCAB1E;

  // Fibonacci taps 16,14,13,11 as zero-based bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int CD_W = 8;

  typedef struct packed {
    logic [31:0]     rdata;
    logic            err;
    logic [CD_W-1:0] countdown;
  } resp_entry_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/tb_obi_responder_if.sv
// rtl/tb_obi_responder_if.sv - core data port req/gnt/rvalid bundle
interface tb_obi_responder_if;
  logic        data_req;
  logic [31:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        data_err;

  modport master (
    output data_req, data_addr, data_we, data_be, data_wdata,
    input  data_gnt, data_rvalid, data_rdata, data_err
  );

  modport slave (
    input  data_req, data_addr, data_we, data_be, data_wdata,
    output data_gnt, data_rvalid, data_rdata, data_err
  );
endinterface

// File: rtl/tb_resp_fifo.sv
// rtl/tb_resp_fifo.sv - in-order response FIFO with per-entry latency countdown
module tb_resp_fifo
  import tb_obi_resp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push,
  input  resp_entry_t push_entry,
  input  logic        pop,
  output resp_entry_t head,
  output logic        full,
  output logic        empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST    = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  resp_entry_t      entries [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  assign head  = entries[rd_ptr];
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      // Countdowns saturate at zero; a freshly pushed entry overrides its slot below
      for (int i = 0; i < DEPTH; i++) begin
        if (entries[i].countdown != '0)
          entries[i].countdown <= entries[i].countdown - CD_W'(1);
      end
      if (push) begin
        entries[wr_ptr] <= push_entry;
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/tb_obi_responder.sv
// rtl/tb_obi_responder.sv - stalling, fixed-latency memory responder for the core data port
module tb_obi_responder
  import tb_obi_resp_pkg::*;
#(
  parameter int          ADDR_WIDTH      = 16,
  parameter int          GNT_STALL       = 0,
  parameter int          RESP_LATENCY    = 1,
  parameter int          MAX_OUTSTANDING = 4,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               rand_stall_en_i,
  tb_obi_responder_if.slave  bus
);
  localparam logic [1:0] IDLE  = GS_IDLE;
  localparam logic [1:0] STALL = GS_STALL;
  localparam logic [1:0] GRANT = GS_GRANT;
  localparam int MEM_WORDS = 2 ** (ADDR_WIDTH - 2);
  localparam int SC_W = (GNT_STALL > 3) ? $clog2(GNT_STALL + 1) : 2;

  logic [1:0]            state;
  logic [SC_W-1:0]       stall_cnt;
  logic [SC_W-1:0]       stall_len;
  logic [15:0]           lfsr;
  logic [31:0]           mem [MEM_WORDS];
  logic [ADDR_WIDTH-3:0] word_idx;
  logic                  in_range;
  logic                  accept;
  logic                  slot_free;
  logic                  rsp_pop;
  logic                  hold_grant;
  logic                  fifo_full;
  logic                  fifo_empty;
  resp_entry_t           head;
  resp_entry_t           new_entry;

  assign word_idx   = bus.data_addr[ADDR_WIDTH-1:2];
  assign in_range   = (bus.data_addr >> ADDR_WIDTH) == 32'd0;
  assign stall_len  = rand_stall_en_i ? SC_W'(lfsr[1:0]) : SC_W'(GNT_STALL);
  // Zero fixed stall keeps GRANT across accepts so a held req streams every cycle
  assign hold_grant = !rand_stall_en_i && (GNT_STALL == 0);

  assign rsp_pop   = !fifo_empty && (head.countdown == '0);
  assign slot_free = !fifo_full || rsp_pop;
  assign accept    = (state == GRANT) && bus.data_req && slot_free;

  assign bus.data_gnt    = accept;
  assign bus.data_rvalid = rsp_pop;
  assign bus.data_rdata  = rsp_pop ? head.rdata : '0;
  assign bus.data_err    = rsp_pop & head.err;

  always_comb begin
    new_entry           = '0;
    new_entry.countdown = CD_W'(RESP_LATENCY - 1);
    new_entry.err       = !in_range;
    if (!in_range)          new_entry.rdata = ERR_RDATA;
    else if (!bus.data_we)  new_entry.rdata = mem[word_idx];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      stall_cnt <= '0;
      lfsr      <= LFSR_SEED;
    end else begin
      case (state)
        IDLE: begin
          if (bus.data_req) begin
            lfsr      <= lfsr_next(lfsr);
            stall_cnt <= stall_len;
            state     <= (stall_len == '0) ? GRANT : STALL;
          end
        end
        STALL: begin
          if (!bus.data_req) begin
            state <= IDLE;
          end else begin
            stall_cnt <= stall_cnt - SC_W'(1);
            if (stall_cnt == SC_W'(1)) state <= GRANT;
          end
        end
        GRANT: begin
          if (!bus.data_req || (accept && !hold_grant)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory contents survive reset so data written before a reset is still readable
  always_ff @(posedge clk_i) begin
    if (accept && bus.data_we && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.data_be[b]) mem[word_idx][8*b +: 8] <= bus.data_wdata[8*b +: 8];
      end
    end
  end

  tb_resp_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push       (accept),
    .push_entry (new_entry),
    .pop        (rsp_pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );
endmodule

// File: tb/tb_tb_obi_responder.sv
// tb/tb_tb_obi_responder.sv - directed bench for three responder configurations
module tb_tb_obi_responder;
  logic clk = 1'b0;
  logic rst;
  logic rand_b;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  tb_obi_responder_if a_if ();
  tb_obi_responder_if b_if ();
  tb_obi_responder_if c_if ();

  tb_obi_responder #(.ADDR_WIDTH(16), .GNT_STALL(0), .RESP_LATENCY(1), .MAX_OUTSTANDING(4),
                     .LFSR_SEED(16'hACE1))
    u_a (.clk_i(clk), .rst_i(rst), .rand_stall_en_i(1'b0), .bus(a_if));
  tb_obi_responder #(.ADDR_WIDTH(16), .GNT_STALL(2), .RESP_LATENCY(1), .MAX_OUTSTANDING(4),
                     .LFSR_SEED(16'hACE1))
    u_b (.clk_i(clk), .rst_i(rst), .rand_stall_en_i(rand_b), .bus(b_if));
  tb_obi_responder #(.ADDR_WIDTH(16), .GNT_STALL(0), .RESP_LATENCY(4), .MAX_OUTSTANDING(2),
                     .LFSR_SEED(16'hACE1))
    u_c (.clk_i(clk), .rst_i(rst), .rand_stall_en_i(1'b0), .bus(c_if));

  logic        c_we   [8];
  logic [31:0] c_addr [8];
  logic [31:0] c_wd   [8];
  int          c_gcyc [8];
  logic [31:0] c_rd   [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag, input logic g, input logic rv,
                           input logic [31:0] rd, input logic er);
    chk({tag, "_gnt"}, 32'(g), 32'd0);
    chk({tag, "_rvalid"}, 32'(rv), 32'd0);
    chk({tag, "_rdata"}, rd, 32'd0);
    chk({tag, "_err"}, 32'(er), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd);
    a_if.data_req = 1'b1; a_if.data_we = we; a_if.data_addr = addr;
    a_if.data_be = be; a_if.data_wdata = wd;
  endtask

  task automatic a_xfer(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, output logic rv, output logic [31:0] rd,
                        output logic er);
    int n;
    a_drive(we, addr, be, wd);
    #1;
    n = 0;
    while (!a_if.data_gnt && n < 20) begin tick(); n++; end
    chk("a_gnt_bound", 32'(n < 20), 32'd1);
    tick();
    a_if.data_req = 1'b0;
    rv = a_if.data_rvalid; rd = a_if.data_rdata; er = a_if.data_err;
  endtask

  task automatic b_xfer(input logic [31:0] addr, output int lat, output logic rv);
    b_if.data_req = 1'b1; b_if.data_we = 1'b0; b_if.data_addr = addr; b_if.data_be = 4'hF;
    #1;
    lat = 0;
    while (!b_if.data_gnt && lat < 20) begin tick(); lat++; end
    tick();
    b_if.data_req = 1'b0;
    rv = b_if.data_rvalid;
  endtask

  task automatic c_drive(input int i);
    c_if.data_req = 1'b1; c_if.data_we = c_we[i]; c_if.data_addr = c_addr[i];
    c_if.data_be = 4'hF; c_if.data_wdata = c_wd[i];
  endtask

  // Holds req across n transactions; cycle 0 is the cycle the first req is raised
  task automatic c_run(input int n, output int first_rv);
    int   idx;
    int   cyc;
    logic acc;
    c_rd.delete();
    first_rv = -1; idx = 0; cyc = 0;
    c_drive(0);
    while (cyc < 200 && (idx < n || c_rd.size() < n)) begin
      #1;
      if (c_if.data_rvalid) begin
        c_rd.push_back(c_if.data_rdata);
        if (first_rv < 0) first_rv = cyc;
      end
      acc = c_if.data_req && c_if.data_gnt;
      if (acc) c_gcyc[idx] = cyc;
      tick();
      cyc++;
      if (acc) begin
        idx++;
        if (idx < n) c_drive(idx); else c_if.data_req = 1'b0;
      end
    end
    chk("c_run_bound", 32'(c_rd.size()), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        rv;
    logic        er;
    logic [31:0] rd;
    logic [31:0] exp_rd;
    int          lat;
    int          frv;
    int          acc;
    int          n;
    int          rvcnt;

    rst = 1'b1; rand_b = 1'b0;
    a_if.data_req = 0; a_if.data_we = 0; a_if.data_addr = 0; a_if.data_be = 0; a_if.data_wdata = 0;
    b_if.data_req = 0; b_if.data_we = 0; b_if.data_addr = 0; b_if.data_be = 0; b_if.data_wdata = 0;
    c_if.data_req = 0; c_if.data_we = 0; c_if.data_addr = 0; c_if.data_be = 0; c_if.data_wdata = 0;
    for (int i = 0; i < 8; i++) begin
      c_we[i]   = (i < 4);
      c_addr[i] = 32'(4 * (i % 4));
      c_wd[i]   = 32'hC0DE0000 + 32'(i);
    end
    tick(); tick();
    chk_quiet("rst_a", a_if.data_gnt, a_if.data_rvalid, a_if.data_rdata, a_if.data_err);
    chk_quiet("rst_b", b_if.data_gnt, b_if.data_rvalid, b_if.data_rdata, b_if.data_err);
    chk_quiet("rst_c", c_if.data_gnt, c_if.data_rvalid, c_if.data_rdata, c_if.data_err);
    rst = 1'b0;
    tick();

    // Back-to-back write then read with zero stall, latency 1
    a_drive(1'b1, 32'h10, 4'hF, 32'h12345678);
    #1;
    chk("a_b2b_gnt_idle", 32'(a_if.data_gnt), 32'd0);
    tick();
    chk("a_b2b_gnt_wr", 32'(a_if.data_gnt), 32'd1);
    tick();
    chk("a_b2b_wr_rvalid", 32'(a_if.data_rvalid), 32'd1);
    chk("a_b2b_wr_rdata", a_if.data_rdata, 32'd0);
    chk("a_b2b_wr_err", 32'(a_if.data_err), 32'd0);
    a_drive(1'b0, 32'h10, 4'hF, 32'h0);
    #1;
    chk("a_b2b_gnt_rd", 32'(a_if.data_gnt), 32'd1);
    tick();
    a_if.data_req = 1'b0;
    chk("a_b2b_rd_rvalid", 32'(a_if.data_rvalid), 32'd1);
    chk("a_b2b_rd_rdata", a_if.data_rdata, 32'h12345678);
    chk("a_b2b_rd_err", 32'(a_if.data_err), 32'd0);
    tick();
    chk("a_b2b_rvalid_drop", 32'(a_if.data_rvalid), 32'd0);

    // Partial byte-enable write
    a_xfer(1'b1, 32'h0, 4'hF, 32'h0, rv, rd, er);
    a_xfer(1'b1, 32'h0, 4'b0101, 32'hAABBCCDD, rv, rd, er);
    chk("a_pw_wr_rvalid", 32'(rv), 32'd1);
    a_xfer(1'b0, 32'h0, 4'hF, 32'h0, rv, rd, er);
    chk("a_pw_rd_rdata", rd, 32'h00BB00DD);

    // Out-of-range accesses; the write aliases word 0x10 and must be dropped
    a_xfer(1'b0, 32'h0010_0000, 4'hF, 32'h0, rv, rd, er);
    chk("a_oor_rd_rvalid", 32'(rv), 32'd1);
    chk("a_oor_rd_err", 32'(er), 32'd1);
    chk("a_oor_rd_rdata", rd, 32'hBADCAB1E);
    a_xfer(1'b1, 32'h0010_0010, 4'hF, 32'hDEADBEEF, rv, rd, er);
    chk("a_oor_wr_err", 32'(er), 32'd1);
    chk("a_oor_wr_rdata", rd, 32'hBADCAB1E);
    a_xfer(1'b0, 32'h10, 4'hF, 32'h0, rv, rd, er);
    chk("a_oor_mem_kept", rd, 32'h12345678);
    chk("a_oor_mem_err", 32'(er), 32'd0);

    // Random stall from seed 0xACE1 (stall 1), then 0x59C3 (stall 3); then fixed stall 2
    rand_b = 1'b1;
    b_xfer(32'h20, lat, rv);
    chk("b_rand_lat0", 32'(lat), 32'd2);
    chk("b_rand_rvalid0", 32'(rv), 32'd1);
    b_xfer(32'h24, lat, rv);
    chk("b_rand_lat1", 32'(lat), 32'd4);
    rand_b = 1'b0;
    b_xfer(32'h28, lat, rv);
    chk("b_fixed_lat", 32'(lat), 32'd3);
    chk("b_fixed_rvalid", 32'(rv), 32'd1);
    tick();
    chk("b_rvalid_drop", 32'(b_if.data_rvalid), 32'd0);

    // Latency 4 with two outstanding: four writes then four reads with req held
    c_run(8, frv);
    chk("c_first_rv_cyc", 32'(frv), 32'd5);
    chk("c_gnt_cyc1", 32'(c_gcyc[1]), 32'd2);
    chk("c_gnt_cyc2_stalled", 32'(c_gcyc[2]), 32'd5);
    chk("c_gnt_cyc3", 32'(c_gcyc[3]), 32'd6);
    for (int i = 0; i < 8; i++) begin
      exp_rd = (i < 4) ? 32'd0 : 32'hC0DE0000 + 32'(i - 4);
      chk($sformatf("c_rsp%0d", i), (i < c_rd.size()) ? c_rd[i] : 32'hxxxxxxxx, exp_rd);
    end

    // Reset with two reads outstanding discards their responses
    c_if.data_req = 1'b1; c_if.data_we = 1'b0; c_if.data_addr = 32'h0; c_if.data_be = 4'hF;
    acc = 0; n = 0;
    while (acc < 2 && n < 20) begin
      #1;
      if (c_if.data_gnt) acc++;
      tick();
      n++;
    end
    chk("c_pre_rst_accepts", 32'(acc), 32'd2);
    chk("c_pre_rst_rvalid", 32'(c_if.data_rvalid), 32'd0);
    rst = 1'b1;
    #1;
    chk_quiet("c_in_rst", c_if.data_gnt, c_if.data_rvalid, c_if.data_rdata, c_if.data_err);
    tick(); tick();
    rst = 1'b0;
    c_if.data_req = 1'b0;
    rvcnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (c_if.data_rvalid) rvcnt++;
    end
    chk("c_post_rst_rvalids", 32'(rvcnt), 32'd0);
    c_we[0] = 1'b0; c_addr[0] = 32'h0;
    c_run(1, frv);
    chk("c_post_rst_lat", 32'(frv), 32'd5);
    chk("c_post_rst_rdata", (c_rd.size() > 0) ? c_rd[0] : 32'hxxxxxxxx, 32'hC0DE0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tb_obi_responder.md
# tb_obi_responder

Testbench data-port responder: the memory/slave end of the core's req/gnt/rvalid data interface. It sits on the core's `data_*` port in place of, or in front of, a plain RAM model. It grants requests after a configurable or pseudo-random stall and returns responses in order after a fixed latency, with a bounded number of outstanding transactions. It exists to stress the core's LSU handshake under controllable back-pressure and response delay.

## Interface
Parameters:
- `ADDR_WIDTH`, 16: byte address width of internal memory; depth 2^(ADDR_WIDTH-2) 32-bit words.
- `GNT_STALL`, 0: fixed cycles between a new request and its grant when random stall is off.
- `RESP_LATENCY`, 1: cycles from accept edge to rvalid; legal range ≥1.
- `MAX_OUTSTANDING`, 4: accepted-but-unanswered transaction limit; legal range ≥1.
- `LFSR_SEED`, 16'hACE1: reset value of stall LFSR; nonzero.

Ports (one clock `clk_i`; reset `rst_i` asynchronous, active-high):
- `clk_i` in 1: clock.
- `rst_i` in 1: async active-high reset.
- `rand_stall_en_i` in 1: 1 = stall length from LFSR[1:0] (0..3); 0 = `GNT_STALL`.
- `data_req_i` in 1: request valid.
- `data_addr_i` in 32: byte address.
- `data_we_i` in 1: 1 = write.
- `data_be_i` in 4: byte enables.
- `data_wdata_i` in 32: write data.
- `data_gnt_o` out 1: grant; a request is accepted on an edge with req & gnt.
- `data_rvalid_o` out 1: response valid, one cycle per accepted transaction.
- `data_rdata_o` out 32: read data; 0 for writes.
- `data_err_o` out 1: valid with rvalid; 1 = out-of-range address.

## Operation
- Grant FSM, states IDLE, STALL, GRANT:
  - IDLE: on `data_req_i`, load stall counter with the stall length (LFSR or `GNT_STALL`). Go to GRANT if 0, else STALL.
  - STALL: decrement the counter; go to GRANT when it reaches 0.
  - GRANT: `data_gnt_o = data_req_i & slot_free`. On accept, return to IDLE. If `data_req_i` is still high, the next request starts its stall in the following cycle.
  - With stall 0 and slot free, back-to-back requests are granted every cycle: GRANT is held while req stays high.
- `slot_free` = (count < `MAX_OUTSTANDING`) or a response retires in the same cycle.
- Requestor rule: req, addr, we, be and wdata must stay stable until gnt.
  - If req drops during STALL or GRANT, the FSM returns to IDLE and the stall is abandoned.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle the FSM leaves IDLE.
- On accept:
  - Write: byte lanes with `be`=1 are written to `mem[addr[ADDR_WIDTH-1:2]]`.
  - Read: the word is sampled, already reflecting every earlier-accepted write.
  - Entry {rdata, err, countdown=`RESP_LATENCY`-1} is pushed to the response FIFO, depth `MAX_OUTSTANDING`.
- Out of range (`addr[31:ADDR_WIDTH]` ≠ 0): write dropped; response rdata = 32'hBADCAB1E, err = 1.
- All FIFO countdowns decrement each cycle. The head is presented (rvalid = 1) when its countdown is 0, then popped; responses are in order.
- count: +1 on accept, −1 on rvalid; both together leaves it unchanged.
- The responder never stalls responses; the core must accept rvalid unconditionally.

## Timing
- Reset values: gnt 0, rvalid 0, rdata 0, err 0, FSM IDLE, count 0, FIFO empty, LFSR = `LFSR_SEED`. Memory contents are not reset.
- Accept on edge T: rvalid is high in the cycle following edge T+`RESP_LATENCY`−1, i.e. L cycles after the accept cycle. With L=1, rvalid is in the cycle immediately after gnt.
- Grant latency: `stall`+1 cycles from req rising to gnt high in IDLE entry.
  - gnt is combinational on `data_req_i` in GRANT; all other outputs are registered.
- Steady-state outstanding depth is min(L, `MAX_OUTSTANDING`). Throughput is 1/cycle only if `MAX_OUTSTANDING` ≥ L.
- Reset asserted mid-transaction: all pending responses are discarded; no rvalid is issued after reset release for pre-reset requests.

## Structure
- Package `tb_obi_resp_pkg`:
  - FSM state enum `gnt_state_e`.
  - `ERR_RDATA` = 32'hBADCAB1E.
  - LFSR tap mask.
  - Response-entry struct `resp_entry_t` {rdata, err, countdown}.
- Sub-module `tb_resp_fifo`: synchronous FIFO of `resp_entry_t` with push, pop, full, empty and per-entry countdown decrement.
- Top module holds the FSM, LFSR, memory array and count.

## Test plan
- `GNT_STALL`=0, L=1: write 32'h12345678 @0x10 (be=4'hF), then read @0x10 back-to-back → gnt on both consecutive cycles; read rvalid has rdata 32'h12345678, err 0.
- `GNT_STALL`=2: single read → gnt 3 cycles after req rises; rvalid 1 cycle later.
- L=4, `MAX_OUTSTANDING`=2, req held for 4 reads → gnt low on the 3rd request until the first rvalid; rvalid order matches address order.
- be=4'b0101, wdata 32'hAABBCCDD over 32'h0 → readback 32'h00BB00DD.
- Read @0x0010_0000 with `ADDR_WIDTH`=16 → rvalid with err 1, rdata 32'hBADCAB1E; memory unchanged.
- Assert `rst_i` with 2 reads outstanding (L=4) → gnt, rvalid, err, rdata 0; no rvalid after release until a new accept.
